// File: rtl/alu_mdu_pkg.sv
// Shared opcodes and multiply/divide FSM states for the EX-stage ALU.
package alu_mdu_pkg;

  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_AND   = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 5'b00001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 5'b00011;
  localparam logic [ALU_OP_W-1:0] ALU_NOR   = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 5'b00111;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 5'b01000;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 5'b01001;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 5'b01010;
  localparam logic [ALU_OP_W-1:0] ALU_MFHI  = 5'b01011;
  localparam logic [ALU_OP_W-1:0] ALU_MFLO  = 5'b01100;
  localparam logic [ALU_OP_W-1:0] ALU_MULT  = 5'b01101;
  localparam logic [ALU_OP_W-1:0] ALU_MULTU = 5'b01110;
  localparam logic [ALU_OP_W-1:0] ALU_DIV   = 5'b01111;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [ALU_OP_W-1:0] op);
    return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Issue/result bundle between the EX stage and alu_mdu.
// The ovf signal exists only when ALU_MDU_OVF_EN is defined.
interface alu_mdu_if #(
  parameter int WIDTH = 32
) ();
  import alu_mdu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  logic                op_valid;
  logic                op_ready;
  logic [ALU_OP_W-1:0] alu_cont;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic [SHW-1:0]      shamt;
  logic                result_valid;
  logic [WIDTH-1:0]    result;
  logic                zero;
  logic                busy;
`ifdef ALU_MDU_OVF_EN
  logic                ovf;
`endif

  modport master (
    output op_valid, alu_cont, a, b, shamt,
`ifdef ALU_MDU_OVF_EN
    input  ovf,
`endif
    input  op_ready, result_valid, result, zero, busy
  );

  modport slave (
    input  op_valid, alu_cont, a, b, shamt,
`ifdef ALU_MDU_OVF_EN
    output ovf,
`endif
    output op_ready, result_valid, result, zero, busy
  );

endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide unit: one bit per cycle over operand magnitudes,
// sign fix-up on the final step, results landing in HI/LO.
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a_save;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             is_signed;
  logic             want_div;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     div_rr;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;

  assign is_signed = (op == ALU_MULT) || (op == ALU_DIV);
  assign want_div  = (op == ALU_DIV) || (op == ALU_DIVU);
  assign sa        = is_signed & a[WIDTH-1];
  assign sb        = is_signed & b[WIDTH-1];
  assign mag_a     = sa ? -a : a;
  assign mag_b     = sb ? -b : b;

  // {acc,qr} is the shifting product; qr's low bit selects the add
  assign mul_sum  = {1'b0, acc} + (qr[0] ? {1'b0, m} : '0);
  assign mul_prod = {mul_sum, qr[WIDTH-1:1]};

  // Restoring step: the remainder stays below the divisor, so a W-bit subtract suffices
  assign div_rr  = {acc, qr[WIDTH-1]};
  assign div_ge  = div_rr >= {1'b0, m};
  assign div_rem = div_ge ? (div_rr[WIDTH-1:0] - m) : div_rr[WIDTH-1:0];
  assign div_quo = {qr[WIDTH-2:0], div_ge};

  assign busy = (state != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      qr     <= '0;
      m      <= '0;
      a_save <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt    <= '0;
            acc    <= '0;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= (b == '0);
            a_save <= a;
            if (want_div) begin
              qr    <= mag_a;
              m     <= mag_b;
              state <= ST_DIV;
            end else begin
              qr    <= mag_b;
              m     <= mag_a;
              state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          acc <= mul_prod[2*WIDTH-1:WIDTH];
          qr  <= mul_prod[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            {hi_q, lo_q} <= neg_q ? -mul_prod : mul_prod;
            state        <= ST_IDLE;
          end
        end
        ST_DIV: begin
          acc <= div_rem;
          qr  <= div_quo;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Divide by zero bypasses the sign fix-up: LO all ones, HI the raw dividend
            if (dz) begin
              lo_q <= '1;
              hi_q <= a_save;
            end else begin
              lo_q <= neg_q ? -div_quo : div_quo;
              hi_q <= neg_r ? -div_rem : div_rem;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Registered EX-stage ALU with an iterative multiply/divide unit and HI/LO.
// Define ALU_MDU_OVF_EN to add the signed ADD/SUB overflow flag (bus.ovf).
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mdu_if.slave bus
);

  logic             busy;
  logic             accept;
  logic             is_mdu;
  logic             start;
  logic             simple_accept;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt_s;
  logic             slt_u;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             valid_q;

  assign sh            = bus.shamt;
  assign accept        = bus.op_valid && !busy;
  assign is_mdu        = is_mdu_op(bus.alu_cont);
  assign start         = accept && is_mdu;
  assign simple_accept = accept && !is_mdu;
  assign sum           = bus.a + bus.b;
  assign diff          = bus.a - bus.b;
  assign slt_s         = $signed(bus.a) < $signed(bus.b);
  assign slt_u         = bus.a < bus.b;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (bus.alu_cont),
    .a     (bus.a),
    .b     (bus.b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    simple_res = '0;
    case (bus.alu_cont)
      ALU_AND:  simple_res = bus.a & bus.b;
      ALU_OR:   simple_res = bus.a | bus.b;
      ALU_ADD:  simple_res = sum;
      ALU_XOR:  simple_res = bus.a ^ bus.b;
      ALU_NOR:  simple_res = ~(bus.a | bus.b);
      ALU_SLTU: simple_res = {{(WIDTH-1){1'b0}}, slt_u};
      ALU_SUB:  simple_res = diff;
      ALU_SLT:  simple_res = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_SLL:  simple_res = bus.b << sh;
      ALU_SRL:  simple_res = bus.b >> sh;
      ALU_SRA:  simple_res = $signed(bus.b) >>> sh;
      ALU_MFHI: simple_res = hi;
      ALU_MFLO: simple_res = lo;
      default:  simple_res = '0;
    endcase
  end

  // result/zero hold between simple ops; MDU ops never touch them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= simple_accept;
      if (simple_accept) begin
        result_q <= simple_res;
        zero_q   <= (simple_res == '0);
      end
    end
  end

  assign bus.op_ready     = !busy;
  assign bus.busy         = busy;
  assign bus.result       = result_q;
  assign bus.zero         = zero_q;
  assign bus.result_valid = valid_q;

`ifdef ALU_MDU_OVF_EN
  logic ovf_next;
  logic ovf_q;

  always_comb begin
    ovf_next = 1'b0;
    if (bus.alu_cont == ALU_ADD)
      ovf_next = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    else if (bus.alu_cont == ALU_SUB)
      ovf_next = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (simple_accept)
      ovf_q <= ovf_next;
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32) using an expected-result queue.
// Covers the ALU_MDU_OVF_EN flag when that macro is defined.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] res;
  } exp_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  sh;
    logic [31:0] res;
  } vec_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
  } mvec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(W)) bus_if ();

  alu_mdu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  exp_t        sb[$];

  vec_t  simple_vecs[13];
  mvec_t mdu_vecs[7];
  logic [4:0] simple_ops[14];
  logic [4:0] mdu_ops[4];

  function automatic logic [31:0] model_simple(input logic [4:0] op, input logic [31:0] x,
                                               input logic [31:0] y, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      ALU_AND:  r = x & y;
      ALU_OR:   r = x | y;
      ALU_ADD:  r = x + y;
      ALU_XOR:  r = x ^ y;
      ALU_NOR:  r = ~(x | y);
      ALU_SLTU: r = (x < y) ? 32'd1 : 32'd0;
      ALU_SUB:  r = x - y;
      ALU_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      ALU_SLL:  r = y << sh;
      ALU_SRL:  r = y >> sh;
      ALU_SRA:  r = $signed(y) >>> sh;
      ALU_MFHI: r = model_hi;
      ALU_MFLO: r = model_lo;
      default:  r = '0;
    endcase
    return r;
  endfunction

  task automatic model_mdu(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      sp;
    logic [63:0] up;
    int          sx;
    int          sy;
    sx = x;
    sy = y;
    case (op)
      ALU_MULT: begin
        sp = longint'(sx) * longint'(sy);
        {model_hi, model_lo} = sp;
      end
      ALU_MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        {model_hi, model_lo} = up;
      end
      ALU_DIV: begin
        if (y == 32'd0) begin
          model_lo = 32'hFFFF_FFFF;
          model_hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          model_lo = 32'h8000_0000;
          model_hi = 32'd0;
        end else begin
          model_lo = sx / sy;
          model_hi = sx % sy;
        end
      end
      default: begin
        if (y == 32'd0) begin
          model_lo = 32'hFFFF_FFFF;
          model_hi = x;
        end else begin
          model_lo = x / y;
          model_hi = x % y;
        end
      end
    endcase
  endtask

  // Waits for op_ready, pushes the expectation, and returns #1 after the accepting edge
  task automatic send_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] sh, input bit use_exp, input logic [31:0] expv);
    int   guard = 0;
    exp_t e;
    bus_if.op_valid = 1'b1;
    bus_if.alu_cont = op;
    bus_if.a        = x;
    bus_if.b        = y;
    bus_if.shamt    = sh;
    while (bus_if.op_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (bus_if.op_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout op=%0d op_ready=%b required=1", op, bus_if.op_ready);
      bus_if.op_valid = 1'b0;
      return;
    end
    if (is_mdu_op(op)) begin
      model_mdu(op, x, y);
    end else begin
      e.op  = op;
      e.res = use_exp ? expv : model_simple(op, x, y, sh);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus_if.op_valid = 1'b0;
  endtask

  task automatic collect(output bit got, output logic [31:0] r, output logic z);
    got = 1'b0;
    r   = '0;
    z   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus_if.result_valid === 1'b1) begin
        got = 1'b1;
        r   = bus_if.result;
        z   = bus_if.zero;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(output int stall, output int stray);
    stall = 0;
    stray = 0;
    while (bus_if.op_ready !== 1'b1 && stall < 100) begin
      if (bus_if.result_valid !== 1'b0) stray++;
      stall++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bit          got;
    logic [31:0] r;
    logic        z;
    exp_t        e;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_if.result !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_result got=%h want=%h", bus_if.result, 32'd0);
    end
    checks++;
    if (bus_if.zero !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_zero got=%b want=1", bus_if.zero);
    end
    checks++;
    if (bus_if.result_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid got=%b want=0", bus_if.result_valid);
    end
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.op_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_busy busy=%b ready=%b want busy=0 ready=1",
                         bus_if.busy, bus_if.op_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      send_op((k == 0) ? ALU_MFHI : ALU_MFLO, 32'd0, 32'd0, 5'd0, 1'b1, 32'd0);
      collect(got, r, z);
      e = sb.pop_front();
      checks++;
      if (!got || r !== e.res || z !== 1'b1) begin
        errors++; $display("[TB] FAIL reset_hilo op=%0d got=%h valid=%b want=%h", e.op, r, got, e.res);
      end
    end
  endtask

  task automatic test_simple();
    bit          got;
    logic [31:0] r;
    logic        z;
    exp_t        e;
    for (int i = 0; i < 13; i++) begin
      send_op(simple_vecs[i].op, simple_vecs[i].x, simple_vecs[i].y, simple_vecs[i].sh,
              1'b1, simple_vecs[i].res);
      collect(got, r, z);
      e = sb.pop_front();
      checks++;
      if (!got || r !== e.res || z !== (e.res == 32'd0)) begin
        errors++;
        $display("[TB] FAIL simple_%0d op=%0d got=%h zero=%b valid=%b want=%h", i, e.op, r, z, got, e.res);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_if.result_valid !== 1'b0 || bus_if.result !== e.res) begin
        errors++;
        $display("[TB] FAIL pulse_hold_%0d valid=%b result=%h want valid=0 result=%h",
                 i, bus_if.result_valid, bus_if.result, e.res);
      end
    end
  endtask

  task automatic test_mdu();
    bit          got;
    logic [31:0] r;
    logic        z;
    exp_t        e;
    int          stall;
    int          stray;
    for (int i = 0; i < 7; i++) begin
      send_op(mdu_vecs[i].op, mdu_vecs[i].x, mdu_vecs[i].y, 5'd0, 1'b0, 32'd0);
      wait_idle(stall, stray);
      checks++;
      if (stall != W || stray != 0) begin
        errors++;
        $display("[TB] FAIL mdu_busy_%0d busy_cycles=%0d stray_valid=%0d want %0d and 0", i, stall, stray, W);
      end
      for (int k = 0; k < 2; k++) begin
        send_op((k == 0) ? ALU_MFHI : ALU_MFLO, 32'd0, 32'd0, 5'd0, 1'b1,
                (k == 0) ? mdu_vecs[i].hi : mdu_vecs[i].lo);
        collect(got, r, z);
        e = sb.pop_front();
        checks++;
        if (!got || r !== e.res) begin
          errors++;
          $display("[TB] FAIL mdu_%0d_%s got=%h valid=%b want=%h", i, (k == 0) ? "hi" : "lo", r, got, e.res);
        end
      end
    end
  endtask

  task automatic test_stall_mflo();
    int stall;
    int stray;
    send_op(ALU_MULT, 32'd6, 32'd7, 5'd0, 1'b0, 32'd0);
    bus_if.op_valid = 1'b1;
    bus_if.alu_cont = ALU_MFLO;
    wait_idle(stall, stray);
    checks++;
    if (stall != W || stray != 0) begin
      errors++;
      $display("[TB] FAIL stall_mflo stall=%0d stray=%0d want %0d and 0", stall, stray, W);
    end
    @(posedge clk); #1;
    bus_if.op_valid = 1'b0;
    checks++;
    if (bus_if.result_valid !== 1'b1 || bus_if.result !== 32'd42) begin
      errors++;
      $display("[TB] FAIL stall_mflo_result valid=%b result=%h want 1 and %h",
               bus_if.result_valid, bus_if.result, 32'd42);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_if.result_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_mflo_single_pulse valid=%b want=0", bus_if.result_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [4:0] op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0] sh;
    bus_if.op_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = simple_ops[$urandom_range(0, 13)];
      x  = $urandom;
      y  = (i == 3) ? x : $urandom;
      sh = 5'($urandom_range(0, 31));
      bus_if.alu_cont = op;
      bus_if.a        = x;
      bus_if.b        = y;
      bus_if.shamt    = sh;
      e.op  = op;
      e.res = model_simple(op, x, y, sh);
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus_if.result_valid !== 1'b1 || bus_if.result !== e.res || bus_if.zero !== (e.res == 32'd0)) begin
        errors++;
        $display("[TB] FAIL b2b_%0d op=%0d valid=%b got=%h want=%h", i, e.op, bus_if.result_valid,
                 bus_if.result, e.res);
      end
    end
    bus_if.op_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit          got;
    logic [31:0] r;
    logic        z;
    exp_t        e;
    int          stall;
    int          stray;
    int          pick;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 30; i++) begin
      pick = $urandom_range(0, 17);
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      y = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom);
      if (pick < 14) begin
        send_op(simple_ops[pick], x, y, 5'($urandom_range(0, 31)), 1'b0, 32'd0);
        collect(got, r, z);
        e = sb.pop_front();
        checks++;
        if (!got || r !== e.res || z !== (e.res == 32'd0)) begin
          errors++;
          $display("[TB] FAIL rand_%0d op=%0d x=%h y=%h got=%h valid=%b want=%h", i, e.op, x, y, r, got, e.res);
        end
      end else begin
        send_op(mdu_ops[pick-14], x, y, 5'd0, 1'b0, 32'd0);
        wait_idle(stall, stray);
        for (int k = 0; k < 2; k++) begin
          send_op((k == 0) ? ALU_MFHI : ALU_MFLO, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
          collect(got, r, z);
          e = sb.pop_front();
          checks++;
          if (!got || r !== e.res) begin
            errors++;
            $display("[TB] FAIL rand_mdu_%0d op=%0d x=%h y=%h read=%0d got=%h want=%h",
                     i, mdu_ops[pick-14], x, y, k, r, e.res);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_mult();
    bit          got;
    logic [31:0] r;
    logic        z;
    exp_t        e;
    send_op(ALU_ADD, 32'd3, 32'd4, 5'd0, 1'b1, 32'd7);
    collect(got, r, z);
    e = sb.pop_front();
    checks++;
    if (!got || r !== e.res) begin
      errors++; $display("[TB] FAIL premult_add got=%h want=%h", r, e.res);
    end
    send_op(ALU_MULT, 32'd5, 32'd7, 5'd0, 1'b0, 32'd0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.op_ready !== 1'b1 || bus_if.result !== 32'd0 ||
        bus_if.zero !== 1'b1 || bus_if.result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset busy=%b ready=%b result=%h zero=%b valid=%b want 0 1 0 1 0",
               bus_if.busy, bus_if.op_ready, bus_if.result, bus_if.zero, bus_if.result_valid);
    end
    rst_n = 1'b1;
    model_hi = '0;
    model_lo = '0;
    sb.delete();
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      send_op((k == 0) ? ALU_MFLO : ALU_MFHI, 32'd0, 32'd0, 5'd0, 1'b1, 32'd0);
      collect(got, r, z);
      e = sb.pop_front();
      checks++;
      if (!got || r !== e.res) begin
        errors++; $display("[TB] FAIL midreset_hilo op=%0d got=%h valid=%b want=%h", e.op, r, got, e.res);
      end
    end
  endtask

`ifdef ALU_MDU_OVF_EN
  task automatic test_ovf();
    bit          got;
    logic [31:0] r;
    logic        z;
    exp_t        e;
    logic [4:0]  ops[4]  = '{ALU_ADD, ALU_SUB, ALU_ADD, ALU_SUB};
    logic [31:0] xs[4]   = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 32'd5};
    logic [31:0] ys[4]   = '{32'd1, 32'd1, 32'd1, 32'd5};
    logic        want[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send_op(ops[i], xs[i], ys[i], 5'd0, 1'b0, 32'd0);
      collect(got, r, z);
      e = sb.pop_front();
      checks++;
      if (!got || bus_if.ovf !== want[i] || r !== e.res) begin
        errors++;
        $display("[TB] FAIL ovf_%0d ovf=%b result=%h want ovf=%b result=%h", i, bus_if.ovf, r, want[i], e.res);
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    simple_vecs[0]  = '{ALU_ADD,  32'h7FFF_FFFF, 32'd1,         5'd0,  32'h8000_0000};
    simple_vecs[1]  = '{ALU_SUB,  32'd5,         32'd5,         5'd0,  32'd0};
    simple_vecs[2]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1};
    simple_vecs[3]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0};
    simple_vecs[4]  = '{ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'h00F0_1200};
    simple_vecs[5]  = '{ALU_OR,   32'hF000_0001, 32'h0000_0F00, 5'd0,  32'hF000_0F01};
    simple_vecs[6]  = '{ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 5'd0,  32'h5555_5555};
    simple_vecs[7]  = '{ALU_NOR,  32'hFFFF_0000, 32'h0000_00FF, 5'd0,  32'h0000_FF00};
    simple_vecs[8]  = '{ALU_SRA,  32'd0,         32'h8000_0000, 5'd4,  32'hF800_0000};
    simple_vecs[9]  = '{ALU_SLL,  32'd0,         32'd1,         5'd31, 32'h8000_0000};
    simple_vecs[10] = '{ALU_SRL,  32'd0,         32'h8000_0000, 5'd31, 32'd1};
    simple_vecs[11] = '{ALU_SRA,  32'd0,         32'h7FFF_FFFF, 5'd31, 32'd0};
    simple_vecs[12] = '{5'b11111, 32'h1234_5678, 32'h1,         5'd0,  32'd0};

    mdu_vecs[0] = '{ALU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    mdu_vecs[1] = '{ALU_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE};
    mdu_vecs[2] = '{ALU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    mdu_vecs[3] = '{ALU_DIVU,  32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF};
    mdu_vecs[4] = '{ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    mdu_vecs[5] = '{ALU_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};
    mdu_vecs[6] = '{ALU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    simple_ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SLTU, ALU_SUB, ALU_SLT,
                   ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFHI, ALU_MFLO, 5'b10101};
    mdu_ops    = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};

    bus_if.op_valid = 1'b0;
    bus_if.alu_cont = '0;
    bus_if.a        = '0;
    bus_if.b        = '0;
    bus_if.shamt    = '0;

    test_reset();
    test_simple();
    test_mdu();
    test_stall_mflo();
    test_back_to_back();
    test_random();
    test_reset_mid_mult();
`ifdef ALU_MDU_OVF_EN
    test_ovf();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
